fetch_stage: RTL and testbench

//  Instruction-fetch stage with IF/ID register feeding control_unit_top: InstrD[6:0]->Op, [14:12]->funct3, [31:25]->funct7.

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one-outstanding imem handshake and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds FetchStallCnt, counting cycles the fetch FSM waits.
module fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemReady,
    input  logic            ImemRvalid,
    input  logic [31:0]     ImemRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
    , output logic [31:0]   FetchStallCnt
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);
    state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d, buf_pc_q, buf_pc_d, pcd_q, pcd_d, pc4_q, pc4_d;
    logic [XLEN-1:0] dpc;
    logic [31:0] buf_q, buf_d, instr_q, instr_d, dword;
    logic drop_q, drop_d, valid_q, valid_d, deliver;
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        buf_d    = buf_q;
        buf_pc_d = buf_pc_q;
        drop_d   = drop_q;
        instr_d  = instr_q;
        pcd_d    = pcd_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        deliver  = 1'b0;
        dword    = buf_q;
        dpc      = buf_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: if (ImemReady) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + FOUR;
                state_d  = WAIT;
                drop_d   = PCSrcE;
            end
            WAIT: if (ImemRvalid) begin
                state_d = REQ;
                drop_d  = 1'b0;
                // Stale, redirected or flushed responses are consumed without reaching IF/ID
                if (!drop_q && !PCSrcE && !FlushD) begin
                    if (StallD) begin
                        buf_d    = ImemRdata;
                        buf_pc_d = req_pc_q;
                        state_d  = HOLD;
                    end else begin
                        deliver = 1'b1;
                        dword   = ImemRdata;
                        dpc     = req_pc_q;
                    end
                end
            end else if (PCSrcE) drop_d = 1'b1;
            HOLD: if (PCSrcE) state_d = REQ;
                else if (!StallD) begin
                    state_d = REQ;
                    deliver = !FlushD;
                end
            default: state_d = IDLE;
        endcase
        if (PCSrcE || FlushD) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (deliver) begin
            valid_d = 1'b1;
            instr_d = dword;
            pcd_d   = dpc;
            pc4_d   = dpc + FOUR;
        end else if (!StallD) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end
        if (PCSrcE) pc_d = PCTargetE & ~XLEN'(3);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            buf_q    <= '0;
            buf_pc_q <= '0;
            drop_q   <= 1'b0;
            instr_q  <= NOP;
            pcd_q    <= '0;
            pc4_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            buf_q    <= buf_d;
            buf_pc_q <= buf_pc_d;
            drop_q   <= drop_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
        end
    end
    assign ImemReq  = state_q == REQ;
    assign ImemAddr = pc_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pc4_q;
    assign ValidD   = valid_q;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic stall_cyc;
    always_comb begin
        stall_cyc = (state_q == REQ && !ImemReady) || (state_q == WAIT && !ImemRvalid) || state_q == HOLD;
        cnt_d = cnt_q + 32'(stall_cyc);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign FetchStallCnt = cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus randomized run against a queue-based fetch model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0100;
    logic clk = 0, rst = 0;
    logic StallD = 0, FlushD = 0, PCSrcE = 0, ImemReady = 0, ImemRvalid = 0;
    logic [31:0] PCTargetE = 0, ImemRdata = 0;
    logic ImemReq, ValidD;
    logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchStallCnt;
`endif
    int tests = 0, fails = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(RPC), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady),
        .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
        , .FetchStallCnt(FetchStallCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
        end
    endtask

    typedef struct {
        logic stall, flush, pcsrc;
        logic [31:0] tgt;
        logic ready, rvalid;
        logic [31:0] rdata;
        logic ereq;
        logic [31:0] eaddr;
        logic evalid;
        logic [31:0] einstr, epcd;
    } vec_t;
    vec_t v[25];

    task automatic apply(input vec_t x);
        StallD = x.stall; FlushD = x.flush; PCSrcE = x.pcsrc; PCTargetE = x.tgt;
        ImemReady = x.ready; ImemRvalid = x.rvalid; ImemRdata = x.rdata;
    endtask

    task automatic check_vec(input int i);
        chk($sformatf("v%0d.req", i), 32'(ImemReq), 32'(v[i].ereq));
        if (v[i].ereq) chk($sformatf("v%0d.addr", i), ImemAddr, v[i].eaddr);
        chk($sformatf("v%0d.valid", i), 32'(ValidD), 32'(v[i].evalid));
        chk($sformatf("v%0d.instr", i), InstrD, v[i].einstr);
        if (v[i].evalid) begin
            chk($sformatf("v%0d.pcd", i), PCD, v[i].epcd);
            chk($sformatf("v%0d.pc4", i), PCPlus4D, v[i].epcd + 32'd4);
        end
    endtask

    // Behavioural model: requests in flight and held words are tracked as queues
    typedef struct { logic [31:0] pc; bit stale; } out_t;
    typedef struct { logic [31:0] word, pc; } word_t;
    out_t  out_q[$];
    word_t hold_q[$];
    bit m_started;
    logic [31:0] m_pc, m_instr, m_pcd, m_cnt;
    bit m_valid;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    task automatic model_reset();
        out_q.delete(); hold_q.delete();
        m_started = 0; m_pc = RPC; m_instr = NOP; m_pcd = 0; m_valid = 0; m_cnt = 0;
    endtask

    function automatic bit m_requesting();
        return m_started && out_q.size() == 0 && hold_q.size() == 0;
    endfunction

    task automatic model_step(input bit stall, flush, pcsrc, ready, rvalid, input logic [31:0] tgt);
        bit dlv = 0;
        word_t w;
        out_t r;
        if (m_requesting() && !ready || out_q.size() != 0 && !rvalid || hold_q.size() != 0) m_cnt++;
        if (!m_started) m_started = 1;
        else if (m_requesting()) begin
            if (ready) begin
                out_q.push_back('{m_pc, pcsrc});
                m_pc += 4;
            end
        end else if (out_q.size() != 0) begin
            if (rvalid) begin
                r = out_q.pop_front();
                if (!r.stale && !pcsrc && !flush) begin
                    if (stall) hold_q.push_back('{mem(r.pc), r.pc});
                    else begin dlv = 1; w = '{mem(r.pc), r.pc}; end
                end
            end else if (pcsrc) out_q[0].stale = 1;
        end else if (pcsrc) hold_q.delete();
        else if (!stall) begin
            w = hold_q.pop_front();
            dlv = !flush;
        end
        if (pcsrc || flush || (!dlv && !stall)) begin
            m_valid = 0; m_instr = NOP;
        end else if (dlv) begin
            m_valid = 1; m_instr = w.word; m_pcd = w.pc;
        end
        if (pcsrc) m_pc = tgt & ~32'd3;
    endtask

    initial begin
        bit pend, acc, rv;
        int lat;
        logic [31:0] raddr, snap;
        v[0]  = '{0,0,0,0,          0,0,0,            1,32'h100,     0,NOP,0};
        v[1]  = '{0,0,0,0,          1,0,0,            0,0,           0,NOP,0};
        v[2]  = '{0,0,0,0,          0,1,32'h00500093, 1,32'h104,     1,32'h00500093,32'h100};
        v[3]  = '{0,0,0,0,          1,0,0,            0,0,           0,NOP,0};
        v[4]  = '{0,0,0,0,          0,1,32'h00308113, 1,32'h108,     1,32'h00308113,32'h104};
        v[5]  = '{1,0,0,0,          1,0,0,            0,0,           1,32'h00308113,32'h104};
        v[6]  = '{1,0,0,0,          0,1,32'h00A00193, 0,0,           1,32'h00308113,32'h104};
        v[7]  = '{1,0,0,0,          0,0,0,            0,0,           1,32'h00308113,32'h104};
        v[8]  = '{1,0,0,0,          0,0,0,            0,0,           1,32'h00308113,32'h104};
        v[9]  = '{0,0,0,0,          0,0,0,            1,32'h10C,     1,32'h00A00193,32'h108};
        v[10] = '{0,0,0,0,          1,0,0,            0,0,           0,NOP,0};
        v[11] = '{0,0,1,32'h203,    0,0,0,            0,0,           0,NOP,0};
        v[12] = '{0,0,0,0,          0,1,32'hDEADBEEF, 1,32'h200,     0,NOP,0};
        v[13] = '{0,0,0,0,          1,0,0,            0,0,           0,NOP,0};
        v[14] = '{0,1,0,0,          0,1,32'h00100213, 1,32'h204,     0,NOP,0};
        v[15] = '{0,0,0,0,          1,0,0,            0,0,           0,NOP,0};
        v[16] = '{0,0,0,0,          0,1,32'h00200293, 1,32'h208,     1,32'h00200293,32'h204};
        v[17] = '{0,0,1,32'hFFFFFFFC,0,0,0,           1,32'hFFFFFFFC,0,NOP,0};
        v[18] = '{0,0,0,0,          1,0,0,            0,0,           0,NOP,0};
        v[19] = '{0,0,0,0,          0,1,32'h00300313, 1,32'h0,       1,32'h00300313,32'hFFFFFFFC};
        for (int i = 20; i < 25; i++) v[i] = '{0,0,0,0, 0,0,0, 1,32'h0, 0,NOP,0};

        repeat (3) @(negedge clk);
        chk("rst.req", 32'(ImemReq), 0);
        chk("rst.valid", 32'(ValidD), 0);
        chk("rst.instr", InstrD, NOP);
        chk("rst.pcd", PCD, 0);
        chk("rst.pc4", PCPlus4D, 0);
        rst = 1;
        snap = 0;
        for (int i = 0; i < 25; i++) begin
`ifdef FETCH_PERF_CNT_EN
            if (i == 20) snap = FetchStallCnt;
`endif
            apply(v[i]);
            @(negedge clk);
            check_vec(i);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf.5cyc", FetchStallCnt, snap + 32'd5);
`endif

        // Reset while a request is outstanding; its response is never returned
        apply(v[1]);
        @(posedge clk);
        #2 rst = 0;
        #1;
        chk("mrst.req", 32'(ImemReq), 0);
        chk("mrst.valid", 32'(ValidD), 0);
        chk("mrst.instr", InstrD, NOP);
        chk("mrst.pcd", PCD, 0);
        apply(v[0]);
        @(negedge clk);
        rst = 1;

        model_reset();
        pend = 0; lat = 0; raddr = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) @(negedge clk);
            chk("rnd.req", 32'(ImemReq), 32'(m_requesting()));
            if (m_requesting()) chk("rnd.addr", ImemAddr, m_pc);
            chk("rnd.valid", 32'(ValidD), 32'(m_valid));
            chk("rnd.instr", InstrD, m_instr);
            if (m_valid) begin
                chk("rnd.pcd", PCD, m_pcd);
                chk("rnd.pc4", PCPlus4D, m_pcd + 32'd4);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("rnd.cnt", FetchStallCnt, m_cnt);
`endif
            rv = pend && lat == 0;
            if (pend && lat != 0) lat--;
            StallD    = $urandom_range(0, 3) == 0;
            FlushD    = $urandom_range(0, 9) == 0;
            PCSrcE    = $urandom_range(0, 11) == 0;
            PCTargetE = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
            ImemReady = $urandom_range(0, 4) < 3;
            ImemRvalid = rv || (!pend && $urandom_range(0, 9) == 0);
            ImemRdata = rv ? mem(raddr) : $urandom;
            acc = ImemReq && ImemReady;
            model_step(StallD, FlushD, PCSrcE, ImemReady, ImemRvalid, PCTargetE);
            if (rv) pend = 0;
            if (acc) begin
                pend = 1;
                raddr = ImemAddr;
                lat = $urandom_range(0, 2);
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
